// File: rtl/data_mover.sv
// data_mover: block COPY/FILL engine that owns the data RAM port and passes the
// CPU straight through when idle. It keeps a byte checksum of what it writes.
module data_mover #(
  parameter int D = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [D-1:0] src,
  input  logic [D-1:0] dst,
  input  logic [D:0]   len,
  input  logic [W-1:0] fill_val,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] checksum,
  output logic         cpu_stall,
  input  logic         cpu_read,
  input  logic         cpu_write,
  input  logic [D-1:0] cpu_addr,
  input  logic [W-1:0] cpu_din,
  output logic         mem_read,
  output logic         mem_write,
  output logic [D-1:0] mem_addr,
  output logic [W-1:0] mem_din,
  input  logic [W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       r_state;
  logic         r_mode;
  logic [D-1:0] r_src;
  logic [D-1:0] r_dst;
  logic [D:0]   r_len;
  logic [D:0]   r_idx;
  logic [W-1:0] r_fill;
  logic [W-1:0] r_buf;
  logic [W-1:0] r_sum;

  logic [W-1:0] w_wdata;
  logic [D:0]   w_idx_nxt;
  logic         w_last;

  // Write data and index bookkeeping for the WR state
  always_comb begin
    w_wdata   = r_mode ? r_fill : r_buf;
    w_idx_nxt = r_idx + {{D{1'b0}}, 1'b1};
    w_last    = (w_idx_nxt == r_len);
  end

  // RAM port mux: CPU owns the port only in IDLE; DONE leaves it quiet
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (r_state)
      S_IDLE: begin
        mem_read  = cpu_read;
        mem_write = cpu_write;
        mem_addr  = cpu_addr;
        mem_din   = cpu_din;
      end
      S_RD: begin
        mem_read = 1'b1;
        mem_addr = r_src + r_idx[D-1:0];
      end
      S_WR: begin
        mem_write = 1'b1;
        mem_addr  = r_dst + r_idx[D-1:0];
        mem_din   = w_wdata;
      end
      S_DONE: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  assign busy      = (r_state == S_RD) || (r_state == S_WR);
  assign done      = (r_state == S_DONE);
  assign checksum  = r_sum;
  assign cpu_stall = busy & (cpu_read | cpu_write);

  // Transfer sequencer; the index is D+1 bits so a full 2**D-byte block is legal
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_fill  <= '0;
      r_buf   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_src  <= src;
            r_dst  <= dst;
            r_len  <= len;
            r_fill <= fill_val;
            r_idx  <= '0;
            r_sum  <= '0;
            if (len == '0) begin
              r_state <= S_DONE;
            end else if (mode) begin
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          r_buf   <= mem_dout;
          r_state <= S_WR;
        end
        S_WR: begin
          r_sum <= r_sum + w_wdata;
          r_idx <= w_idx_nxt;
          if (w_last) begin
            r_state <= S_DONE;
          end else if (r_mode) begin
            r_state <= S_WR;
          end else begin
            r_state <= S_RD;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mover.sv
// Self-checking bench for data_mover: a RAM behind the DUT, a transfer-level
// reference model that predicts every cycle, and random plus directed transfers.
module tb_data_mover;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] src;
  logic [7:0] dst;
  logic [8:0] len;
  logic [7:0] fill_val;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic       cpu_stall;
  logic       cpu_read;
  logic       cpu_write;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_din;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  data_mover #(.D(8), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .checksum(checksum),
    .cpu_stall(cpu_stall), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram     [0:255] = '{default: 8'h00};
  logic [7:0] ref_mem [0:255] = '{default: 8'h00};

  assign mem_dout = ram[mem_addr];
  always @(posedge clk) if (mem_write) ram[mem_addr] <= mem_din;

  typedef struct {
    logic       busy;
    logic       done;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] cs;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] model_cs = 8'h00;
  logic chk_en = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc_ctr = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0;
  int b_cyc = 0, b_busy = 0, b_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model's queue; an empty queue means pass-through
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      cyc_ctr++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_ctr;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctl", 32'({busy, done, mem_read, mem_write, cpu_stall}),
              32'({e.busy, e.done, e.rd, e.wr, e.busy & (cpu_read | cpu_write)}));
        if (e.rd | e.wr) check("addr", 32'(mem_addr), 32'(e.addr));
        if (e.wr) check("wdata", 32'(mem_din), 32'(e.din));
        check("cksum", 32'(checksum), 32'(e.cs));
      end else begin
        check("idle", 32'({busy, done, cpu_stall, mem_read, mem_write, mem_addr, mem_din, checksum}),
              32'({3'b000, cpu_read, cpu_write, cpu_addr, cpu_din, model_cs}));
      end
    end
  end

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] v);
    cpu_write = 1'b1;
    cpu_addr  = a;
    cpu_din   = v;
    @(posedge clk); #1;
    cpu_write = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic ram_cmp(input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) if (ram[k] !== ref_mem[k]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  // One transfer: model predicts each cycle; limit>0 asserts reset in that cycle
  task automatic xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                      input logic [8:0] n, input logic [7:0] f, input int limit,
                      input logic contend);
    logic [7:0] cs, v, a;
    int cyc, t_len;
    exp_t e;
    start = 1'b1; mode = m; src = s; dst = d; len = n; fill_val = f;
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 1'($urandom); src = 8'($urandom); dst = 8'($urandom);
    len = 9'($urandom); fill_val = 8'($urandom);
    b_cyc = cyc_ctr; b_busy = busy_cnt; b_done = done_cnt;
    cs = 8'h00;
    cyc = 0;
    for (int j = 0; j < int'(n); j++) begin
      if (!m) begin
        cyc++;
        if (limit == 0 || cyc <= limit) begin
          e = '{busy: 1'b1, done: 1'b0, rd: 1'b1, wr: 1'b0, addr: 8'(s + j), din: 8'h00, cs: cs};
          exp_q.push_back(e);
        end
      end
      a = 8'(d + j);
      v = m ? f : ref_mem[8'(s + j)];
      cyc++;
      if (limit == 0 || cyc <= limit) begin
        e = '{busy: 1'b1, done: 1'b0, rd: 1'b0, wr: 1'b1, addr: a, din: v, cs: cs};
        exp_q.push_back(e);
        ref_mem[a] = v;
      end
      cs = cs + v;
    end
    if (limit == 0) begin
      e = '{busy: 1'b0, done: 1'b1, rd: 1'b0, wr: 1'b0, addr: 8'h00, din: 8'h00, cs: cs};
      exp_q.push_back(e);
    end
    model_cs = (limit == 0) ? cs : 8'h00;
    t_len = exp_q.size();
    if (contend) begin
      cpu_write = 1'b1;
      cpu_addr = 8'($urandom);
      cpu_din = 8'($urandom);
    end
    for (int c = 1; c <= t_len; c++) begin
      if (limit != 0 && c == limit) rst_n = 1'b0;
      if (contend && (c == 2 || c == t_len)) start = 1'b1;
      if (contend && c == 3) start = 1'b0;
      if (limit == 0 && c == t_len) cpu_write = 1'b0;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    start = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = 8'h00; dst = 8'h00;
    len = 9'h000; fill_val = 8'h00;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 8'h00; cpu_din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state and pass-through
    cpu_write = 1'b1; cpu_addr = 8'h10; cpu_din = 8'hA5;
    #1;
    check("pt_write", 32'({mem_read, mem_write, mem_addr, mem_din}), 32'({1'b0, 1'b1, 8'h10, 8'hA5}));
    check("rst_state", 32'({busy, done, cpu_stall, checksum}), 32'd0);
    @(posedge clk); #1;
    cpu_write = 1'b0;
    ref_mem[8'h10] = 8'hA5;

    // COPY of four bytes
    for (int k = 0; k < 4; k++) cpu_wr(8'(8'h20 + k), 8'(k + 1));
    xfer(1'b0, 8'h20, 8'h80, 9'd4, 8'h00, 0, 1'b0);
    check("copy_busy", 32'(busy_cnt - b_busy), 32'd8);
    check("copy_done_cyc", 32'(done_cyc - b_cyc), 32'd9);
    check("copy_cksum", 32'(checksum), 32'h0A);
    check("copy_data", {ram[8'h80], ram[8'h81], ram[8'h82], ram[8'h83]}, 32'h01020304);
    ram_cmp("copy_ram");

    // FILL wrapping past the top of memory
    xfer(1'b1, 8'h00, 8'hFE, 9'd4, 8'h55, 0, 1'b0);
    check("fill_busy", 32'(busy_cnt - b_busy), 32'd4);
    check("fill_done_cyc", 32'(done_cyc - b_cyc), 32'd5);
    check("fill_cksum", 32'(checksum), 32'h54);
    check("fill_data", {ram[8'hFE], ram[8'hFF], ram[8'h00], ram[8'h01]}, 32'h55555555);
    ram_cmp("fill_ram");

    // Zero length
    xfer(1'b0, 8'h20, 8'h90, 9'd0, 8'h00, 0, 1'b0);
    check("len0_done_cyc", 32'(done_cyc - b_cyc), 32'd1);
    check("len0_busy", 32'(busy_cnt - b_busy), 32'd0);
    check("len0_cksum", 32'(checksum), 32'h00);

    // Full-memory FILL
    xfer(1'b1, 8'h00, 8'h37, 9'd256, 8'h01, 0, 1'b0);
    check("full_busy", 32'(busy_cnt - b_busy), 32'd256);
    check("full_cksum", 32'(checksum), 32'h00);
    ram_cmp("full_ram");

    // Overlapping COPY replicates the first byte
    cpu_wr(8'h60, 8'h9C);
    xfer(1'b0, 8'h60, 8'h61, 9'd5, 8'h00, 0, 1'b0);
    check("overlap_data", 32'({ram[8'h61], ram[8'h65]}), 32'h9C9C);
    ram_cmp("overlap_ram");

    // CPU contention plus ignored restarts
    xfer(1'b0, 8'h00, 8'hA0, 9'd6, 8'h00, 0, 1'b1);
    check("contend_dones", 32'(done_cnt - b_done), 32'd1);
    ram_cmp("contend_ram");

    // Abort by reset during cycle 5 of an 8-byte COPY
    for (int k = 0; k < 8; k++) cpu_wr(8'(8'h40 + k), 8'(8'h11 * (k + 1)));
    for (int k = 0; k < 8; k++) cpu_wr(8'(8'hC0 + k), 8'hEE);
    xfer(1'b0, 8'h40, 8'hC0, 9'd8, 8'h00, 5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_dones", 32'(done_cnt - b_done), 32'd0);
    check("abort_data", 32'({ram[8'hC0], ram[8'hC1], ram[8'hC2]}), 32'h1122EE);
    check("abort_cksum", 32'(checksum), 32'h00);
    ram_cmp("abort_ram");

    // Randomized transfers
    for (int t = 0; t < 30; t++) begin
      logic [8:0] n;
      for (int k = 0; k < 4; k++) cpu_wr(8'($urandom), 8'($urandom));
      n = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 256)) : 9'($urandom_range(0, 24));
      xfer(1'($urandom), 8'($urandom), 8'($urandom), n, 8'($urandom), 0, 1'($urandom));
      check("rnd_dones", 32'(done_cnt - b_done), 32'd1);
      ram_cmp("rnd_ram");
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
